// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_resolve
// Purpose  : ID-stage branch resolution with a full signed condition set,
//            a table of 2-bit saturating predictors looked up by IF, a
//            combinational mispredict flag for the hazard unit, and
//            saturating performance counters.
// Ports    :
//   clk               in   rising-edge clock
//   reset             in   asynchronous active-low reset
//   if_pc             in   PC being fetched (predictor lookup)
//   predict_taken     out  MSB of the predictor entry for if_pc
//   id_valid          in   ID holds a real instruction
//   id_stall          in   ID stalled; suppresses update and counting
//   id_pc             in   PC of the instruction in ID
//   BranchType        in   0 none,1 BEQ,2 BNE,3 BLEZ,4 BGTZ,5 BLTZ,6 BGEZ,7 rsvd
//   id_predicted      in   prediction carried from IF
//   ReadData1         in   rs operand
//   ReadData2         in   rt operand (BEQ/BNE only)
//   bht_clear         in   synchronous clear of all predictor entries
//   branch_taken      out  resolved outcome (combinational)
//   mispredict        out  resolved outcome differs from id_predicted
//   branch_count      out  resolved branches since reset (saturating)
//   mispredict_count  out  mispredicts since reset (saturating)
// Revision : 1.0  initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int INDEX_LSB  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  predict_taken,
    input  logic                  id_valid,
    input  logic                  id_stall,
    input  logic [PC_WIDTH-1:0]   id_pc,
    input  logic [2:0]            BranchType,
    input  logic                  id_predicted,
    input  logic [DATA_WIDTH-1:0] ReadData1,
    input  logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  bht_clear,
    output logic                  branch_taken,
    output logic                  mispredict,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int         C_IDX_W     = $clog2(BHT_DEPTH);
    localparam logic [1:0] C_ENTRY_RST = 2'b01;
    localparam logic [2:0] C_BT_BEQ    = 3'd1;
    localparam logic [2:0] C_BT_BNE    = 3'd2;
    localparam logic [2:0] C_BT_BLEZ   = 3'd3;
    localparam logic [2:0] C_BT_BGTZ   = 3'd4;
    localparam logic [2:0] C_BT_BLTZ   = 3'd5;
    localparam logic [2:0] C_BT_BGEZ   = 3'd6;

    logic [1:0]           bht_q [BHT_DEPTH];
    logic [1:0]           bht_d [BHT_DEPTH];
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [C_IDX_W-1:0]   w_if_idx;
    logic [C_IDX_W-1:0]   w_id_idx;
    logic                 w_rs_neg;
    logic                 w_rs_zero;
    logic                 w_cond;
    logic                 w_active;
    logic                 w_update;
    logic                 w_unused_pc_bits;

    assign w_if_idx = if_pc[INDEX_LSB +: C_IDX_W];
    assign w_id_idx = id_pc[INDEX_LSB +: C_IDX_W];

    // PC bits outside the index field deliberately do not affect the table.
    assign w_unused_pc_bits = ^{if_pc, id_pc};

    // No bypass: IF sees the registered entry even when ID updates it this cycle.
    assign predict_taken = bht_q[w_if_idx][1];

    // Zero compares only need the sign bit and an all-zero test.
    assign w_rs_neg  = ReadData1[DATA_WIDTH-1];
    assign w_rs_zero = (ReadData1 == '0);

    always_comb begin
        w_cond = 1'b0;
        case (BranchType)
            C_BT_BEQ:  w_cond = (ReadData1 == ReadData2);
            C_BT_BNE:  w_cond = (ReadData1 != ReadData2);
            C_BT_BLEZ: w_cond = w_rs_neg | w_rs_zero;
            C_BT_BGTZ: w_cond = ~w_rs_neg & ~w_rs_zero;
            C_BT_BLTZ: w_cond = w_rs_neg;
            C_BT_BGEZ: w_cond = ~w_rs_neg;
            default:   w_cond = 1'b0;
        endcase
    end

    assign w_active     = id_valid && (BranchType >= C_BT_BEQ) && (BranchType <= C_BT_BGEZ);
    assign branch_taken = w_active & w_cond;
    assign mispredict   = w_active & (w_cond != id_predicted);
    assign w_update     = w_active & ~id_stall;

    // Clear has priority over the training update, but not over counting.
    always_comb begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (bht_clear) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_d[i] = C_ENTRY_RST;
            end
        end else if (w_update) begin
            if (w_cond) begin
                if (bht_q[w_id_idx] != 2'b11) begin
                    bht_d[w_id_idx] = bht_q[w_id_idx] + 2'b01;
                end
            end else begin
                if (bht_q[w_id_idx] != 2'b00) begin
                    bht_d[w_id_idx] = bht_q[w_id_idx] - 2'b01;
                end
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (w_update) begin
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    bht_q[g] <= C_ENTRY_RST;
                end else begin
                    bht_q[g] <= bht_d[g];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_resolve
// Purpose  : Self-checking bench for branch_predict_resolve. Each driven
//            cycle pushes its expected combinational outputs onto a
//            scoreboard queue; they are popped and compared mid-cycle.
//            Counters are compared after each clock edge against a
//            behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_resolve;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_pc;
    logic [2:0]  BranchType;
    logic        id_predicted;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        bht_clear;
    logic        branch_taken;
    logic        mispredict;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    branch_predict_resolve #(
        .DATA_WIDTH (32),
        .PC_WIDTH   (32),
        .BHT_DEPTH  (16),
        .INDEX_LSB  (2),
        .CNT_WIDTH  (16)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .predict_taken    (predict_taken),
        .id_valid         (id_valid),
        .id_stall         (id_stall),
        .id_pc            (id_pc),
        .BranchType       (BranchType),
        .id_predicted     (id_predicted),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .bht_clear        (bht_clear),
        .branch_taken     (branch_taken),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic bt;
        logic mp;
        logic pt;
    } exp_t;

    exp_t        sb_q [$];
    logic [1:0]  m_tbl [16];
    logic [15:0] m_bc;
    logic [15:0] m_mc;
    int          n_total;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] t, input logic [31:0] a,
                                      input logic [31:0] b);
        case (t)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) <= 32'sd0;
            3'd4:    return $signed(a) >  32'sd0;
            3'd5:    return $signed(a) <  32'sd0;
            3'd6:    return $signed(a) >= 32'sd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
        m_bc = '0;
        m_mc = '0;
        sb_q.delete();
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic step(input logic [31:0] ifpc, input logic v, input logic st,
                        input logic [31:0] idpc, input logic [2:0] bt, input logic pr,
                        input logic [31:0] a, input logic [31:0] b, input logic clr);
        exp_t       e;
        logic       act;
        logic       c;
        logic [3:0] ii;
        logic [3:0] di;
        ii = ifpc[5:2];
        di = idpc[5:2];
        act = v && (bt >= 3'd1) && (bt <= 3'd6);
        c   = ref_cond(bt, a, b);
        if_pc = ifpc; id_valid = v; id_stall = st; id_pc = idpc; BranchType = bt;
        id_predicted = pr; ReadData1 = a; ReadData2 = b; bht_clear = clr;
        e.bt = act & c;
        e.mp = act & (c != pr);
        e.pt = m_tbl[ii][1];
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
        chk("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
        chk("predict_taken", {31'd0, predict_taken}, {31'd0, e.pt});
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
        end else if (act && !st) begin
            if (c && m_tbl[di] != 2'b11) m_tbl[di] = m_tbl[di] + 2'b01;
            else if (!c && m_tbl[di] != 2'b00) m_tbl[di] = m_tbl[di] - 2'b01;
        end
        if (act && !st) begin
            if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
            if (c != pr && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
        end
        #1;
        chk("branch_count", {16'd0, branch_count}, {16'd0, m_bc});
        chk("mispredict_count", {16'd0, mispredict_count}, {16'd0, m_mc});
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(ifpc, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b0; if_pc = '0; id_valid = 1'b0; id_stall = 1'b0; id_pc = '0;
        BranchType = '0; id_predicted = 1'b0; ReadData1 = '0; ReadData2 = '0;
        bht_clear = 1'b0;
        model_reset();

        // Reset state
        #2;
        if_pc = 32'h0000_0040;
        #1;
        chk("rst_predict", {31'd0, predict_taken}, 32'd0);
        chk("rst_branch_count", {16'd0, branch_count}, 32'd0);
        chk("rst_mispredict_count", {16'd0, mispredict_count}, 32'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // BEQ taken, predicted not taken -> mispredict, entry 01 -> 10
        step(32'h40, 1, 0, 32'h40, 3'd1, 0, 32'd5, 32'd5, 0);
        idle(32'h40);

        // Signed zero-compare set
        step(32'h0, 1, 0, 32'h44, 3'd5, 0, 32'hFFFF_FFFF, 32'h0, 0);
        step(32'h0, 1, 0, 32'h48, 3'd4, 1, 32'h0, 32'h0, 0);
        step(32'h0, 1, 0, 32'h4C, 3'd3, 0, 32'h0, 32'h0, 0);
        step(32'h0, 1, 0, 32'h50, 3'd6, 1, 32'h8000_0000, 32'h0, 0);
        step(32'h0, 1, 0, 32'h50, 3'd2, 1, 32'd7, 32'd7, 0);

        // Types 0/7 and a bubble never resolve
        step(32'h44, 1, 0, 32'h44, 3'd0, 1, 32'd3, 32'd3, 0);
        step(32'h44, 1, 0, 32'h44, 3'd7, 1, 32'd3, 32'd3, 0);
        step(32'h44, 0, 0, 32'h44, 3'd1, 1, 32'd3, 32'd3, 0);

        // Saturation at 11, then one not-taken -> 10 still predicts taken
        for (int k = 0; k < 4; k++) step(32'h58, 1, 0, 32'h58, 3'd1, 0, 32'd1, 32'd1, 0);
        step(32'h58, 1, 0, 32'h58, 3'd1, 1, 32'd1, 32'd2, 0);
        idle(32'h58);

        // Aliasing IF/ID indices: old value this cycle, new next cycle
        step(32'h70, 1, 0, 32'h30, 3'd2, 0, 32'd1, 32'd2, 0);
        idle(32'h70);

        // Stall suppresses update and count
        step(32'h34, 1, 1, 32'h34, 3'd1, 0, 32'd9, 32'd9, 0);
        idle(32'h34);

        // Clear with simultaneous update: table cleared, counts advance
        step(32'h20, 1, 0, 32'h20, 3'd1, 0, 32'd4, 32'd4, 0);
        step(32'h20, 1, 0, 32'h20, 3'd1, 0, 32'd4, 32'd4, 0);
        step(32'h20, 1, 0, 32'h24, 3'd1, 0, 32'd4, 32'd4, 1);
        idle(32'h20);
        idle(32'h24);

        // Random mix checked against the reference model
        for (int k = 0; k < 40; k++) begin
            step({26'd0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) == 0), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                 ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom,
                 1'($urandom_range(0, 15) == 0));
        end

        // Train an entry, then assert reset mid-cycle
        for (int k = 0; k < 2; k++) step(32'h58, 1, 0, 32'h58, 3'd1, 0, 32'd1, 32'd1, 0);
        if_pc = 32'h58; id_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_predict", {31'd0, predict_taken}, {31'd0, m_tbl[4'd6][1]});
        chk("midrst_branch_count", {16'd0, branch_count}, {16'd0, m_bc});
        chk("midrst_mispredict_count", {16'd0, mispredict_count}, {16'd0, m_mc});
        #2 reset = 1'b1;
        @(posedge clk); #1;
        idle(32'h58);
        idle(32'h40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
